// File: rtl/conv_result_drain.sv
// Frame buffer at the end of the convolution pipeline. It captures OUT_DIM x OUT_DIM
// result words in row-major order, then streams them back out tagged with row and column.
// Latency: out_valid rises 2 cycles after the edge that accepts the final write. After that,
// one word per cycle is delivered while out_ready stays high.
// Backpressure: the write side has none, so in_ready is advisory and writes seen outside
// FILL are dropped and flagged. The read side holds each word stable until it is accepted.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   wr_valid/wr_data/wr_last result word input (wr_last marks end of frame)
//   in_ready                 high while the buffer accepts words (FILL)
//   out_valid/out_ready      read-back handshake
//   out_data/out_row/out_col read-back word and its image coordinates
//   out_last                 marks the final word of the frame
//   frame_done               one-cycle pulse after the final word is accepted
//   err_ovf, err_drop        sticky error flags: buffer filled without wr_last / write while draining
module conv_result_drain #(
  parameter int DATA_W  = 16,
  parameter int OUT_DIM = 30,
  parameter int AW      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        out_row,
  output logic [4:0]        out_col,
  output logic              out_last,
  output logic              frame_done,
  output logic              err_ovf,
  output logic              err_drop
);

  localparam int            N        = OUT_DIM * OUT_DIM;
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [4:0]    DIM_M1   = 5'(OUT_DIM - 1);

  // PRIME is the single cycle between the final write and the first buffer read.
  // It keeps the first-word latency fixed at two cycles.
  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_PRIME = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q;
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [AW:0]         count_q;
  logic [4:0]          row_q;      // coordinates of the next word to be loaded
  logic [4:0]          col_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [4:0]          out_row_q;
  logic [4:0]          out_col_q;
  logic                out_last_q;
  logic                frame_done_q;
  logic                err_ovf_q;
  logic                err_drop_q;

  logic [DATA_W-1:0]   mem_q [N];

  logic                hs_d;
  logic                load_d;
  logic                mem_we_d;

  assign hs_d     = out_valid_q & out_ready;
  assign mem_we_d = (state_q == S_FILL) & wr_valid;
  // Load the output register in two cases: the first word after PRIME, or any accepted
  // word other than the last one (prefetch). An accepted last word ends the frame instead.
  assign load_d   = (state_q == S_DRAIN) & (~out_valid_q | (hs_d & ~out_last_q));

  // Buffer storage has no reset; its contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_drop_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      case (state_q)
        S_FILL: begin
          if (wr_valid) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
            if (wr_last) begin
              count_q    <= {1'b0, wr_ptr_q} + (AW+1)'(1);
              state_q    <= S_PRIME;
              in_ready_q <= 1'b0;
            end else if (wr_ptr_q == LAST_IDX) begin
              // The buffer is full but no end-of-frame marker arrived: drain what was captured.
              count_q    <= (AW+1)'(N);
              err_ovf_q  <= 1'b1;
              state_q    <= S_PRIME;
              in_ready_q <= 1'b0;
            end
          end
        end

        S_PRIME: begin
          state_q <= S_DRAIN;
        end

        S_DRAIN: begin
          if (load_d) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mem_q[rd_ptr_q];
            out_row_q   <= row_q;
            out_col_q   <= col_q;
            out_last_q  <= ({1'b0, rd_ptr_q} == (count_q - (AW+1)'(1)));
            rd_ptr_q    <= rd_ptr_q + AW'(1);
            // Generate row/col with a wrapping column counter and a row counter instead of a divider.
            if (col_q == DIM_M1) begin
              col_q <= '0;
              row_q <= (row_q == DIM_M1) ? 5'd0 : row_q + 5'd1;
            end else begin
              col_q <= col_q + 5'd1;
            end
          end else if (hs_d) begin
            // The final word was accepted: close the frame and rearm for the next one.
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            row_q        <= '0;
            col_q        <= '0;
            state_q      <= S_FILL;
            in_ready_q   <= 1'b1;
          end
        end

        default: begin
          state_q <= S_FILL;
        end
      endcase

      // Upstream cannot be stalled, so a write outside FILL is lost; flag it.
      if ((state_q != S_FILL) && wr_valid) begin
        err_drop_q <= 1'b1;
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign err_ovf    = err_ovf_q;
  assign err_drop   = err_drop_q;

endmodule

// File: tb/tb_conv_result_drain.sv
// Scoreboard bench for conv_result_drain: stimulus queues the expected read-back words,
// and an independent monitor checks each accepted word, stall stability and frame_done pulses.
module tb_conv_result_drain;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_last;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_row;
  logic [4:0]  out_col;
  logic        out_last;
  logic        frame_done;
  logic        err_ovf;
  logic        err_drop;

  conv_result_drain #(.DATA_W(16), .OUT_DIM(30), .AW(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .frame_done (frame_done),
    .err_ovf    (err_ovf),
    .err_drop   (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [4:0]  r;
    logic [4:0]  c;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   total   = 0;
  int   bad     = 0;
  int   fd_cnt  = 0;
  int   pop_cnt = 0;
  int   fd_base = 0;
  int   pop_base = 0;
  bit   bp_mode = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the expected word on every handshake and checks hold-stability while stalled.
  initial begin : mon
    exp_t e;
    exp_t held;
    bit   stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (frame_done) fd_cnt++;
        if (stall) begin
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_hold", {5'd0, out_data, out_row, out_col, out_last}, {5'd0, held});
        end
        if (out_valid && out_ready) begin
          chk("sb_nonempty", {31'd0, (exp_q.size() != 0)}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("data", {16'd0, out_data}, {16'd0, e.d});
            chk("row",  {27'd0, out_row},  {27'd0, e.r});
            chk("col",  {27'd0, out_col},  {27'd0, e.c});
            chk("last", {31'd0, out_last}, {31'd0, e.l});
          end
          pop_cnt++;
        end
        stall = out_valid && !out_ready;
        held  = {out_data, out_row, out_col, out_last};
      end
    end
  end

  // Consumer ready: held high, or driven in the pattern 1,0,0,1 when backpressure is on.
  initial begin : rdy_drv
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      cyc++;
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_last = 1'b0;
    wr_data = '0;
    exp_q.delete();
    tick();
    tick();
    chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
    chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
    chk("rst_out_data",   {16'd0, out_data},   32'd0);
    chk("rst_row_col",    {22'd0, out_row, out_col}, 32'd0);
    chk("rst_out_last",   {31'd0, out_last},   32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_err_ovf",    {31'd0, err_ovf},    32'd0);
    chk("rst_err_drop",   {31'd0, err_drop},   32'd0);
    rst = 1'b0;
    tick();
  endtask

  // Writes n words base+i, one per cycle. The final word carries wr_last when with_last is set.
  task automatic write_frame(input int n, input logic [15:0] base, input bit with_last);
    exp_t e;
    fd_base  = fd_cnt;
    pop_base = pop_cnt;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 16'(i);
      wr_last  = with_last && (i == n - 1);
      e.d = base + 16'(i);
      e.r = 5'(i / 30);
      e.c = 5'(i % 30);
      e.l = (i == n - 1);
      exp_q.push_back(e);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Called just after the edge that accepted the final write.
  task automatic check_start(input string tag);
    chk({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_lat0"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_lat2"}, {31'd0, out_valid}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (fd_cnt == fd_base && n < 5000) begin
      tick();
      n++;
    end
    tick();
    tick();
    tick();
    chk({tag, "_frame_done_cnt"}, fd_cnt - fd_base, 32'd1);
    chk({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    chk({tag, "_valid_low"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready_high"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin : stim
    int n;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    wr_data  = '0;
    do_reset();

    // Full frame: words 0..899 with coordinates derived from the index.
    write_frame(900, 16'h0000, 1'b1);
    check_start("full");
    wait_done("full");
    chk("full_err_ovf", {31'd0, err_ovf}, 32'd0);

    // Backpressure during drain.
    bp_mode = 1'b1;
    write_frame(12, 16'h0100, 1'b1);
    check_start("bp");
    wait_done("bp");
    bp_mode = 1'b0;

    // Short frame, then a 3-word frame, then a single-word frame.
    write_frame(5, 16'hA000, 1'b1);
    check_start("short5");
    wait_done("short5");
    write_frame(3, 16'h0001, 1'b1);
    check_start("short3");
    wait_done("short3");
    write_frame(1, 16'h5555, 1'b1);
    check_start("single");
    wait_done("single");

    // Overflow: the buffer fills without wr_last.
    write_frame(900, 16'h2000, 1'b0);
    chk("ovf_set", {31'd0, err_ovf}, 32'd1);
    check_start("ovf");
    wait_done("ovf");
    write_frame(3, 16'h3000, 1'b1);
    check_start("post_ovf");
    wait_done("post_ovf");
    chk("ovf_sticky", {31'd0, err_ovf}, 32'd1);

    // A write during drain is dropped and flagged.
    chk("drop_clear_before", {31'd0, err_drop}, 32'd0);
    write_frame(20, 16'h4000, 1'b1);
    check_start("drop");
    wr_valid = 1'b1;
    wr_data  = 16'hFFFF;
    tick();
    wr_valid = 1'b0;
    chk("drop_set", {31'd0, err_drop}, 32'd1);
    wait_done("drop");

    // Reset in the middle of a drain.
    write_frame(900, 16'h0000, 1'b1);
    check_start("mid");
    n = 0;
    while (pop_cnt < pop_base + 10 && n < 2000) begin
      tick();
      n++;
    end
    chk("mid_ten_read", pop_cnt - pop_base, 32'd10);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    do_reset();
    tick();
    chk("mid_no_frame_done", fd_cnt - fd_base, 32'd0);
    write_frame(900, 16'h6000, 1'b1);
    check_start("after_rst");
    wait_done("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_result_drain.md
Name: conv_result_drain

Overview:
- Terminal sink of the convolution pipeline.
- Captures each finished 16-bit output pixel from the accumulate stage into an internal frame buffer of OUT_DIM x OUT_DIM entries (row-major).
- On end-of-frame, switches to read-back and streams the buffer out over a valid/ready interface, tagging each word with its row/col.
- Acts as the reader for the pipeline's result writer.

Parameters:
- DATA_W, 16, width of result words.
- OUT_DIM, 30, output image side (convolution output of a 32x32 image with a 3x3 filter); frame depth N = OUT_DIM*OUT_DIM = 900.
- AW, 10, buffer index width; must satisfy 2^AW >= N.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_valid  input  1  result word present this cycle (accumulate stage enable).
- wr_data  input  DATA_W  result word.
- wr_last  input  1  end-of-frame marker, qualified by wr_valid.
- in_ready  output  1  high while in FILL. Advisory only: the upstream pipeline has no backpressure.
- out_valid  output  1  read-back word valid.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_W  read-back word.
- out_row  output  5  row index of out_data (0..OUT_DIM-1).
- out_col  output  5  column index of out_data (0..OUT_DIM-1).
- out_last  output  1  high with the final word of the frame.
- frame_done  output  1  one-cycle pulse after the final word handshake.
- err_ovf  output  1  sticky: frame filled the buffer without wr_last.
- err_drop  output  1  sticky: wr_valid seen while not in FILL.

Behaviour:
- Reset values (async, rst=1):
  - State FILL, wr_ptr=0, rd_ptr=0, count=0.
  - in_ready=1.
  - out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0.
  - frame_done=0, err_ovf=0, err_drop=0.
  - Buffer contents are don't-care.
- State FILL:
  - Each cycle with wr_valid=1: write wr_data to mem[wr_ptr], wr_ptr++.
  - If wr_valid and wr_last: count = wr_ptr+1, go to DRAIN.
  - Else if wr_valid and wr_ptr == N-1: count = N, set err_ovf, go to DRAIN.
  - wr_last with wr_valid=0 is ignored.
- State DRAIN:
  - in_ready=0.
  - wr_valid=1 sets err_drop; data is discarded; the buffer is not written.
  - out_valid rises exactly 2 cycles after the accepting edge of the final write (1 cycle state change, 1 cycle registered buffer read).
  - Word k is presented with out_row = k / OUT_DIM and out_col = k % OUT_DIM. Generate these with a wrapping column counter and a row counter, not a divider.
  - Handshake = out_valid & out_ready. On handshake the next word is presented on the following cycle (prefetch). Throughput is 1 word/cycle while out_ready is held high.
  - While out_valid=1 and out_ready=0: out_data, out_row, out_col and out_last hold stable; out_valid does not drop.
  - out_last=1 exactly when word index == count-1.
  - Handshake on the last word:
    - out_valid=0 next cycle.
    - frame_done=1 for one cycle (same cycle out_valid falls).
    - wr_ptr=0, rd_ptr=0, return to FILL.
- Short frame (wr_last before N words): only count words are drained. The remaining buffer content is not emitted.
- Single-word frame (wr_last on the first write): count=1. One word is drained at row 0, col 0 with out_last=1.
- err_ovf and err_drop clear only on reset. They do not block operation.
- Reset asserted mid-FILL or mid-DRAIN: immediate return to reset values. A partial frame is abandoned and no frame_done is issued.
- Width rules: wr_data is stored unmodified (no saturation or truncation). Row/col counters are 5 bits and wrap at OUT_DIM-1.

Test Plan:
- Full frame: write 900 words data=k, wr_last on k=899, out_ready=1 -> out_valid 2 cycles later; 900 consecutive words 0..899; word 31 has row 1 / col 1; word 899 has row 29 / col 29 with out_last=1; frame_done pulses once; err_ovf=0.
- Backpressure: out_ready toggling 1,0,0,1 during drain -> each word holds stable while stalled; no word lost or duplicated; order preserved.
- Short frame: 5 writes 0xA000..0xA004, wr_last on the 5th -> exactly 5 words out; out_last on 0xA004 (row 0, col 4); then a second 3-word frame 1,2,3 drains correctly from index 0.
- Overflow: 900 writes, no wr_last -> err_ovf=1 after the 900th write; 900 words drained; next frame still accepted; err_ovf stays 1.
- Drop: wr_valid=1, data=0xFFFF during DRAIN -> err_drop=1; drained data unchanged.
- Reset mid-drain: assert rst after 10 words read -> out_valid=0 and in_ready=1 immediately; no frame_done; new 900-word frame drains from word 0.
